pio_multi_channel: RTL and testbench

//   Parametrised successor to the single 10-bit output PIO: NUM_CH independent GPIO channels,

---
 rtl/pio_multi_pkg.sv | 20 ++
 rtl/pio_multi_channel_if.sv | 13 +
 rtl/pio_channel.sv | 112 +++++++++++
 rtl/pio_multi_channel.sv | 100 ++++++++++
 tb/tb_pio_multi_channel.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pio_multi_pkg.sv
// Shared constants for the multi-channel PIO: register offsets, edge selection and warm-up length.
package pio_multi_pkg;

    localparam logic [2:0] REG_DATA    = 3'd0;
    localparam logic [2:0] REG_DIR     = 3'd1;
    localparam logic [2:0] REG_IRQMASK = 3'd2;
    localparam logic [2:0] REG_EDGECAP = 3'd3;
    localparam logic [2:0] REG_OUTSET  = 3'd4;
    localparam logic [2:0] REG_OUTCLR  = 3'd5;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_type_e;

    // Cycles after reset release during which edge capture is held off while the synchronisers fill
    localparam int WARMUP_CYCLES = 3;

endpackage

// File: rtl/pio_multi_channel_if.sv
// Avalon-MM slave bus of the multi-channel PIO; read data has a fixed latency of one clock.
interface pio_multi_channel_if #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic [31:0]       avs_readdata;

    modport master (output avs_address, avs_read, avs_write, avs_writedata, input avs_readdata);
    modport slave  (input avs_address, avs_read, avs_write, avs_writedata, output avs_readdata);
endinterface

// File: rtl/pio_channel.sv
// One GPIO channel: output latch, direction, irq mask, input sync/filter and edge capture.
// Input filter is a debounce counter when PIO_DEBOUNCE_EN is defined, a plain pass-through otherwise.
module pio_channel
    import pio_multi_pkg::*;
#(
    parameter int               WIDTH           = 10,
    parameter int               EDGE_TYPE       = 0,
`ifdef PIO_DEBOUNCE_EN
    parameter int               DEBOUNCE_CYCLES = 65536,
`endif
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             edge_en,
    input  logic             wr_en,
    input  logic [2:0]       reg_sel,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    input  logic [WIDTH-1:0] pad_in,
    output logic [WIDTH-1:0] out_latch,
    output logic [WIDTH-1:0] out_en,
    output logic             irq_term
);

    localparam edge_type_e EDGE = edge_type_e'(EDGE_TYPE);

    logic [WIDTH-1:0] sync_q1, sync_q2, filtered, prev_q;
    logic [WIDTH-1:0] mask_q, cap_q, edges, cap_clr;

`ifdef PIO_DEBOUNCE_EN
    localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [WIDTH-1:0] last_q, filt_q;
    logic [CNT_W-1:0] cnt_q;

    // Any change in the synchronised vector restarts the stability count for the whole channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
            filt_q <= '0;
            cnt_q  <= '0;
        end else begin
            last_q <= sync_q2;
            if (sync_q2 != last_q)   cnt_q <= '0;
            else if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CNT_MAX)    filt_q <= last_q;
        end
    end
    assign filtered = filt_q;
`else
    assign filtered = sync_q2;
`endif

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        edges = '0;
        if (edge_en) begin
            case (EDGE)
                EDGE_RISE: edges = filtered & ~prev_q;
                EDGE_FALL: edges = ~filtered & prev_q;
                default:   edges = filtered ^ prev_q;
            endcase
        end
    end

    // A fresh edge wins over a simultaneous write-1-to-clear of the same bit
    assign cap_clr = (wr_en && reg_sel == REG_EDGECAP) ? wdata : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1   <= '0;
            sync_q2   <= '0;
            prev_q    <= '0;
            out_latch <= RESET_VALUE;
            out_en    <= '0;
            mask_q    <= '0;
            cap_q     <= '0;
        end else begin
            sync_q1 <= pad_in;
            sync_q2 <= sync_q1;
            prev_q  <= filtered;
            cap_q   <= (cap_q & ~cap_clr) | edges;
            if (wr_en) begin
                case (reg_sel)
                    REG_DATA:    out_latch <= wdata;
                    REG_DIR:     out_en    <= wdata;
                    REG_IRQMASK: mask_q    <= wdata;
                    REG_OUTSET:  out_latch <= out_latch | wdata;
                    REG_OUTCLR:  out_latch <= out_latch & ~wdata;
                    default:     ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_DATA:    rdata = filtered;
            REG_DIR:     rdata = out_en;
            REG_IRQMASK: rdata = mask_q;
            REG_EDGECAP: rdata = cap_q;
            default:     rdata = '0;
        endcase
    end

    assign irq_term = |(cap_q & mask_q);

endmodule

// File: rtl/pio_multi_channel.sv
// NUM_CH-channel GPIO block behind one Avalon-MM slave; address = {channel, reg[2:0]}.
// Optional input debounce is enabled by defining PIO_DEBOUNCE_EN.
module pio_multi_channel
    import pio_multi_pkg::*;
#(
    parameter int               NUM_CH          = 4,
    parameter int               WIDTH           = 10,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0,
    parameter int               DEBOUNCE_CYCLES = 65536
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset_n,
    pio_multi_channel_if.slave      avs,
    output logic                    irq,
    input  logic [NUM_CH*WIDTH-1:0] pio_in,
    output logic [NUM_CH*WIDTH-1:0] pio_out,
    output logic [NUM_CH*WIDTH-1:0] pio_oe
);

    localparam int ADDR_W = $clog2(NUM_CH) + 3;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WARM_W = $clog2(WARMUP_CYCLES + 1);

    if (NUM_CH < 1 || NUM_CH > 8)         begin : g_bad_num_ch   $error("NUM_CH out of range");     end
    if (WIDTH < 1 || WIDTH > 32)          begin : g_bad_width    $error("WIDTH out of range");      end
    if (EDGE_TYPE < 0 || EDGE_TYPE > 2)   begin : g_bad_edge     $error("EDGE_TYPE out of range");  end
    if (DEBOUNCE_CYCLES < 1)              begin : g_bad_debounce $error("DEBOUNCE_CYCLES < 1");     end

    logic [CH_W-1:0]  ch_idx;
    logic             ch_valid;
    logic [2:0]       reg_sel;
    logic [WIDTH-1:0] ch_rdata [NUM_CH];
    logic [NUM_CH-1:0] irq_terms;
    logic [31:0]      rd_mux, readdata_q;
    logic [WARM_W-1:0] warm_q;
    logic             edge_en;

    assign reg_sel = avs.avs_address[2:0];

    if (NUM_CH == 1) begin : g_single
        assign ch_idx   = '0;
        assign ch_valid = 1'b1;
    end else begin : g_multi
        assign ch_idx   = avs.avs_address[ADDR_W-1:3];
        assign ch_valid = 32'(ch_idx) < NUM_CH;
    end

    // Holds off edge capture until the synchronisers carry real pad values
    assign edge_en = (warm_q == WARM_W'(WARMUP_CYCLES));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n)  warm_q <= '0;
        else if (!edge_en)   warm_q <= warm_q + 1'b1;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pio_channel #(
            .WIDTH           (WIDTH),
            .EDGE_TYPE       (EDGE_TYPE),
`ifdef PIO_DEBOUNCE_EN
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
`endif
            .RESET_VALUE     (RESET_VALUE)
        ) u_ch (
            .clk       (clk_clk),
            .rst_n     (reset_reset_n),
            .edge_en   (edge_en),
            .wr_en     (avs.avs_write && ch_valid && ch_idx == CH_W'(c)),
            .reg_sel   (reg_sel),
            .wdata     (avs.avs_writedata[WIDTH-1:0]),
            .rdata     (ch_rdata[c]),
            .pad_in    (pio_in[c*WIDTH +: WIDTH]),
            .out_latch (pio_out[c*WIDTH +: WIDTH]),
            .out_en    (pio_oe[c*WIDTH +: WIDTH]),
            .irq_term  (irq_terms[c])
        );
    end

    // Unmapped channels fall through to zero; channels already return zero for offsets 4..7
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_valid && ch_idx == CH_W'(c)) rd_mux = 32'(ch_rdata[c]);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            readdata_q <= '0;
            irq        <= 1'b0;
        end else begin
            if (avs.avs_read) readdata_q <= rd_mux;
            irq <= |irq_terms;
        end
    end

    assign avs.avs_readdata = readdata_q;

endmodule

// File: tb/tb_pio_multi_channel.sv
// Directed bench for pio_multi_channel: 3 channels x 10 bits, rising-edge capture, reset value 0x155.
module tb_pio_multi_channel;

    localparam int NUM_CH = 3;
    localparam int WIDTH  = 10;
    localparam int AW     = $clog2(NUM_CH) + 3;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    irq;
    logic [NUM_CH*WIDTH-1:0] pio_in, pio_out, pio_oe;
    logic [31:0]             rdata;
    int                      n_vec = 0;
    int                      n_err = 0;

    always #5 clk = ~clk;

    pio_multi_channel_if #(.ADDR_W(AW)) avs_bus ();

    pio_multi_channel #(
        .NUM_CH          (NUM_CH),
        .WIDTH           (WIDTH),
        .EDGE_TYPE       (0),
        .RESET_VALUE     (10'h155),
        .DEBOUNCE_CYCLES (16)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .avs           (avs_bus),
        .irq           (irq),
        .pio_in        (pio_in),
        .pio_out       (pio_out),
        .pio_oe        (pio_oe)
    );

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input int ch, input int r, input logic [31:0] d);
        avs_bus.avs_address   = AW'(ch * 8 + r);
        avs_bus.avs_writedata = d;
        avs_bus.avs_write     = 1'b1;
        step();
        avs_bus.avs_write     = 1'b0;
    endtask

    task automatic bus_read(input int ch, input int r, output logic [31:0] d);
        avs_bus.avs_address = AW'(ch * 8 + r);
        avs_bus.avs_read    = 1'b1;
        step();
        avs_bus.avs_read    = 1'b0;
        d = avs_bus.avs_readdata;
    endtask

    task automatic test_reset;
        step(3);
        n_vec++; if (pio_out !== {3{10'h155}}) begin n_err++; $display("FAIL reset_pio_out: got %h want %h", pio_out, {3{10'h155}}); end
        n_vec++; if (pio_oe !== '0) begin n_err++; $display("FAIL reset_pio_oe: got %h want 0", pio_oe); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_vec++; if (avs_bus.avs_readdata !== 32'h0) begin n_err++; $display("FAIL reset_readdata: got %h want 0", avs_bus.avs_readdata); end
        rst_n = 1'b1;
        step(6);
        for (int c = 0; c < NUM_CH; c++) begin
            bus_read(c, 3, rdata);
            n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL warmup_edgecap_ch%0d: got %h want 0", c, rdata); end
        end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL warmup_irq: got %b want 0", irq); end
        pio_in = '0;
        step(6);
        bus_read(0, 3, rdata);
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL falling_ignored: got %h want 0", rdata); end
        bus_read(0, 0, rdata);
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL data_in_low: got %h want 0", rdata); end
    endtask

    task automatic test_data_out;
        bus_write(1, 0, 32'h3FF);
        n_vec++; if (pio_out[19:10] !== 10'h3FF) begin n_err++; $display("FAIL data_write: got %h want 3ff", pio_out[19:10]); end
        bus_write(1, 5, 32'h00F);
        n_vec++; if (pio_out !== {10'h155, 10'h3F0, 10'h155}) begin n_err++; $display("FAIL outclr: got %h want %h", pio_out, {10'h155, 10'h3F0, 10'h155}); end
        bus_read(1, 5, rdata);
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL outclr_read: got %h want 0", rdata); end
        bus_write(1, 4, 32'h005);
        n_vec++; if (pio_out[19:10] !== 10'h3F5) begin n_err++; $display("FAIL outset: got %h want 3f5", pio_out[19:10]); end
        bus_write(1, 1, 32'hFFFF_F2AA);
        n_vec++; if (pio_oe !== {10'h0, 10'h2AA, 10'h0}) begin n_err++; $display("FAIL dir_oe: got %h want %h", pio_oe, {10'h0, 10'h2AA, 10'h0}); end
        bus_read(1, 1, rdata);
        n_vec++; if (rdata !== 32'h2AA) begin n_err++; $display("FAIL dir_read_upper_zero: got %h want 2aa", rdata); end
        pio_in[19:10] = 10'h123;
        step(3);
        bus_read(1, 0, rdata);
        n_vec++; if (rdata !== 32'h123) begin n_err++; $display("FAIL data_read_input: got %h want 123", rdata); end
    endtask

    task automatic test_edge_irq;
        bus_write(2, 2, 32'h008);
        bus_read(2, 2, rdata);
        n_vec++; if (rdata !== 32'h008) begin n_err++; $display("FAIL mask_read: got %h want 008", rdata); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL unmasked_no_irq: got %b want 0", irq); end
        pio_in[23] = 1'b1;
        step(2);
        avs_bus.avs_address = AW'(2 * 8 + 3);
        avs_bus.avs_read    = 1'b1;
        step();
        n_vec++; if (avs_bus.avs_readdata !== 32'h0) begin n_err++; $display("FAIL edgecap_before_3clk: got %h want 0", avs_bus.avs_readdata); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_before_4clk: got %b want 0", irq); end
        step();
        avs_bus.avs_read = 1'b0;
        n_vec++; if (avs_bus.avs_readdata !== 32'h008) begin n_err++; $display("FAIL edgecap_at_3clk: got %h want 008", avs_bus.avs_readdata); end
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_at_4clk: got %b want 1", irq); end
    endtask

    task automatic test_w1c;
        pio_in[23] = 1'b0;
        step(4);
        pio_in[23] = 1'b1;
        step(2);
        avs_bus.avs_address   = AW'(2 * 8 + 3);
        avs_bus.avs_writedata = 32'h008;
        avs_bus.avs_write     = 1'b1;
        step();
        avs_bus.avs_write     = 1'b0;
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL collide_irq_a: got %b want 1", irq); end
        step();
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL collide_irq_b: got %b want 1", irq); end
        bus_read(2, 3, rdata);
        n_vec++; if (rdata !== 32'h008) begin n_err++; $display("FAIL collide_edgecap: got %h want 008", rdata); end
        bus_write(2, 3, 32'h008);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL clear_irq_lag: got %b want 1", irq); end
        step();
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL clear_irq_drop: got %b want 0", irq); end
        bus_read(2, 3, rdata);
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL clear_edgecap: got %h want 0", rdata); end
        pio_in[23] = 1'b0;
        step(4);
        pio_in[23] = 1'b1;
        step(5);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL rearm_irq: got %b want 1", irq); end
        bus_write(2, 2, 32'h000);
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL unmask_irq_lag: got %b want 1", irq); end
        step();
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL unmask_irq_drop: got %b want 0", irq); end
        bus_read(2, 3, rdata);
        n_vec++; if (rdata !== 32'h008) begin n_err++; $display("FAIL unmask_keeps_cap: got %h want 008", rdata); end
        bus_write(2, 3, 32'h3FF);
    endtask

    task automatic test_invalid;
        bus_read(1, 1, rdata);
        bus_write(3, 0, 32'h3FF);
        bus_write(0, 6, 32'h3FF);
        bus_write(0, 7, 32'h3FF);
        n_vec++; if (pio_out !== {10'h155, 10'h3F5, 10'h155}) begin n_err++; $display("FAIL invalid_write_out: got %h want %h", pio_out, {10'h155, 10'h3F5, 10'h155}); end
        n_vec++; if (pio_oe !== {10'h0, 10'h2AA, 10'h0}) begin n_err++; $display("FAIL invalid_write_oe: got %h want %h", pio_oe, {10'h0, 10'h2AA, 10'h0}); end
        bus_read(3, 0, rdata);
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL read_bad_channel: got %h want 0", rdata); end
        bus_read(1, 1, rdata);
        bus_read(0, 6, rdata);
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL read_reg6: got %h want 0", rdata); end
        bus_read(1, 1, rdata);
        step(3);
        n_vec++; if (avs_bus.avs_readdata !== 32'h2AA) begin n_err++; $display("FAIL readdata_hold: got %h want 2aa", avs_bus.avs_readdata); end
    endtask

    task automatic test_read_write_same;
        avs_bus.avs_address   = AW'(1 * 8 + 1);
        avs_bus.avs_writedata = 32'h155;
        avs_bus.avs_read      = 1'b1;
        avs_bus.avs_write     = 1'b1;
        step();
        avs_bus.avs_read      = 1'b0;
        avs_bus.avs_write     = 1'b0;
        n_vec++; if (avs_bus.avs_readdata !== 32'h2AA) begin n_err++; $display("FAIL rw_pre_write: got %h want 2aa", avs_bus.avs_readdata); end
        n_vec++; if (pio_oe[19:10] !== 10'h155) begin n_err++; $display("FAIL rw_write_applied: got %h want 155", pio_oe[19:10]); end
        bus_read(1, 1, rdata);
        n_vec++; if (rdata !== 32'h155) begin n_err++; $display("FAIL rw_readback: got %h want 155", rdata); end
    endtask

    task automatic test_reset_mid;
        pio_in[0] = 1'b1;
        step(4);
        bus_read(0, 3, rdata);
        n_vec++; if (rdata !== 32'h001) begin n_err++; $display("FAIL ch0_edgecap: got %h want 001", rdata); end
        bus_write(0, 2, 32'h001);
        step();
        n_vec++; if (irq !== 1'b1) begin n_err++; $display("FAIL ch0_irq: got %b want 1", irq); end
        bus_read(1, 1, rdata);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++; if (avs_bus.avs_readdata !== 32'h0) begin n_err++; $display("FAIL midreset_readdata: got %h want 0", avs_bus.avs_readdata); end
        n_vec++; if (irq !== 1'b0) begin n_err++; $display("FAIL midreset_irq: got %b want 0", irq); end
        n_vec++; if (pio_out !== {3{10'h155}}) begin n_err++; $display("FAIL midreset_out: got %h want %h", pio_out, {3{10'h155}}); end
        n_vec++; if (pio_oe !== '0) begin n_err++; $display("FAIL midreset_oe: got %h want 0", pio_oe); end
        step(2);
        rst_n = 1'b1;
        step(2);
        bus_read(0, 2, rdata);
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL midreset_mask: got %h want 0", rdata); end
    endtask

`ifdef PIO_DEBOUNCE_EN
    task automatic test_debounce;
        pio_in[1] = 1'b1;
        step(5);
        pio_in[1] = 1'b0;
        step(40);
        bus_read(0, 3, rdata);
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL debounce_glitch: got %h want 0", rdata); end
        pio_in[1] = 1'b1;
        step(60);
        bus_read(0, 3, rdata);
        n_vec++; if (rdata !== 32'h002) begin n_err++; $display("FAIL debounce_hold: got %h want 002", rdata); end
        bus_write(0, 3, 32'h3FF);
        step(40);
        bus_read(0, 3, rdata);
        n_vec++; if (rdata !== 32'h0) begin n_err++; $display("FAIL debounce_single: got %h want 0", rdata); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        rst_n                 = 1'b0;
        pio_in                = '1;
        avs_bus.avs_address   = '0;
        avs_bus.avs_read      = 1'b0;
        avs_bus.avs_write     = 1'b0;
        avs_bus.avs_writedata = '0;
        test_reset;
`ifdef PIO_DEBOUNCE_EN
        test_debounce;
`else
        test_data_out;
        test_edge_irq;
        test_w1c;
        test_invalid;
        test_read_write_same;
        test_reset_mid;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
